// File: rtl/coeff_assemble.sv
// ----------------------------------------------------------------------------
// coeff_assemble
//
// Rebuilds one block of scan-order coefficients from the separately decoded
// CAVLC pieces: levels (highest frequency first), total_zeros and the
// run_before values.  The levels are buffered, then placed into a 16-entry
// coefficient array walking from the highest occupied position downwards.
// Finally the array is streamed out in scan order with a valid/ready
// handshake.
//
// Parameters
//   MAX_COEFF     coefficients per block (16 luma 4x4, 15 AC, 4 chroma DC)
//
// Ports
//   Clk           rising-edge clock
//   nReset        asynchronous active-low reset
//   Enable        block active; deasserting it aborts the block
//   TotalCoeff    coefficient count, sampled in IDLE
//   LevelIn/Wr    level value and write strobe
//   TotalZeros/Wr total_zeros value and strobe
//   RunIn/Wr      run_before value and strobe
//   RunReq        high while a run_before value is required
//   CoeffOut      scan-order coefficient (13-bit two's complement)
//   CoeffIdx      scan index of CoeffOut
//   CoeffValid    CoeffOut/CoeffIdx valid
//   OutReady      downstream accept
//   Done          one-cycle pulse on the transfer of index MAX_COEFF-1
//   Error         sticky per-block error flag
//
// Configuration
//   COEFF_ASSEMBLE_ERRCHK_EN  when defined, illegal counts and runs raise
//                             Error and are clamped; otherwise Error is 0.
// ----------------------------------------------------------------------------
module coeff_assemble #(
  parameter int unsigned MAX_COEFF = 16
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Enable,
  input  logic [4:0]  TotalCoeff,
  input  logic [12:0] LevelIn,
  input  logic        LevelWr,
  input  logic [3:0]  TotalZeros,
  input  logic        TotalZerosWr,
  input  logic [3:0]  RunIn,
  input  logic        RunWr,
  output logic        RunReq,
  output logic [12:0] CoeffOut,
  output logic [3:0]  CoeffIdx,
  output logic        CoeffValid,
  input  logic        OutReady,
  output logic        Done,
  output logic        Error
);

  localparam logic [4:0] MaxCoeff = 5'(MAX_COEFF);
  localparam logic [4:0] MaxPos   = 5'(MAX_COEFF - 1);
  localparam logic [3:0] MaxIdx   = 4'(MAX_COEFF - 1);

  typedef enum logic [2:0] {StIdle, StLevels, StZeros, StRuns, StEmit} stateT;

  stateT       stateQ, stateD;
  logic [4:0]  totalCoeffQ, totalCoeffD;
  logic [4:0]  kQ, kD;
  logic [4:0]  posQ, posD;
  logic [4:0]  zerosLeftQ, zerosLeftD;
  logic [3:0]  emitIdxQ, emitIdxD;
  logic [12:0] levelBufQ [16];
  logic [12:0] levelBufD [16];
  logic [12:0] coeffArrQ [16];
  logic [12:0] coeffArrD [16];

  logic        lastCoeff;
  logic        needRun;
  logic        runStep;
  logic        transfer;
  logic        emitLast;
  logic [4:0]  tcLatch;
  logic [4:0]  runVal;
  logic [4:0]  posInit;
  logic [4:0]  posStep;
  logic [5:0]  zerosSum;
  logic [5:0]  posInitRaw;
  logic [5:0]  posStepRaw;

`ifdef COEFF_ASSEMBLE_ERRCHK_EN
  logic        errorQ, errorD;
  logic        tcOver;
  logic        sumOver;
  logic        runOver;
`endif

  // kQ counts levels in LEVELS and placed coefficients in RUNS.
  assign lastCoeff = (kQ == totalCoeffQ - 5'd1);
  // A run_before is only coded while zeros remain and this is not the last
  // coefficient; the last one absorbs all remaining zeros.
  assign needRun   = !lastCoeff && (zerosLeftQ != 5'd0);
  assign runStep   = Enable && (stateQ == StRuns) && (!needRun || RunWr);
  assign transfer  = CoeffValid && OutReady;
  assign emitLast  = (emitIdxQ == MaxIdx);

  // --------------------------------------------------------------------------
  // Run / position arithmetic (with optional checking and clamping)
  // --------------------------------------------------------------------------
  always_comb begin
    tcLatch    = TotalCoeff;
    runVal     = needRun ? {1'b0, RunIn} : (lastCoeff ? zerosLeftQ : 5'd0);
    zerosSum   = {1'b0, totalCoeffQ} + {2'b00, TotalZeros};
    posInitRaw = zerosSum - 6'd1;
`ifdef COEFF_ASSEMBLE_ERRCHK_EN
    tcOver  = (TotalCoeff > MaxCoeff);
    if (tcOver) begin
      tcLatch = MaxCoeff;
    end
    sumOver = (zerosSum > {1'b0, MaxCoeff});
    runOver = needRun && ({1'b0, RunIn} > zerosLeftQ);
    if (runOver) begin
      runVal = zerosLeftQ;
    end
`endif
    posStepRaw = {1'b0, posQ} - 6'd1 - {1'b0, runVal};
    posInit    = posInitRaw[4:0];
    posStep    = posStepRaw[4:0];
`ifdef COEFF_ASSEMBLE_ERRCHK_EN
    // Underflow wraps to a large 6-bit value, so one compare catches both.
    if (posInitRaw > {1'b0, MaxPos}) begin
      posInit = MaxPos;
    end
    if (posStepRaw > {1'b0, MaxPos}) begin
      posStep = MaxPos;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        stateD = (tcLatch == 5'd0) ? StEmit : StLevels;
      end
      StLevels: begin
        if (LevelWr && lastCoeff) begin
          // A full block has no zeros to code, so total_zeros is skipped.
          stateD = (totalCoeffQ == MaxCoeff) ? StRuns : StZeros;
        end
      end
      StZeros: begin
        if (TotalZerosWr) begin
          stateD = StRuns;
        end
      end
      StRuns: begin
        if (runStep && lastCoeff) begin
          stateD = StEmit;
        end
      end
      StEmit: begin
        if (transfer && emitLast) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
    // Enable low aborts from anywhere, including IDLE.
    if (!Enable) begin
      stateD = StIdle;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    CoeffValid = (stateQ == StEmit);
    CoeffIdx   = CoeffValid ? emitIdxQ : 4'd0;
    CoeffOut   = CoeffValid ? coeffArrQ[emitIdxQ] : 13'd0;
    RunReq     = (stateQ == StRuns) && needRun;
    Done       = CoeffValid && OutReady && emitLast;
  end

`ifdef COEFF_ASSEMBLE_ERRCHK_EN
  assign Error = errorQ;
`else
  assign Error = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    totalCoeffD = totalCoeffQ;
    kD          = kQ;
    posD        = posQ;
    zerosLeftD  = zerosLeftQ;
    emitIdxD    = emitIdxQ;
    levelBufD   = levelBufQ;
    coeffArrD   = coeffArrQ;
`ifdef COEFF_ASSEMBLE_ERRCHK_EN
    errorD      = errorQ;
`endif

    if (!Enable) begin
      emitIdxD = 4'd0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          totalCoeffD = tcLatch;
          kD          = 5'd0;
          emitIdxD    = 4'd0;
          for (int i = 0; i < 16; i++) begin
            coeffArrD[i] = 13'd0;
          end
`ifdef COEFF_ASSEMBLE_ERRCHK_EN
          errorD = tcOver;
`endif
        end
        StLevels: begin
          if (LevelWr) begin
            levelBufD[kQ[3:0]] = LevelIn;
            if (lastCoeff) begin
              kD = 5'd0;
              if (totalCoeffQ == MaxCoeff) begin
                posD       = MaxPos;
                zerosLeftD = 5'd0;
              end
            end else begin
              kD = kQ + 5'd1;
            end
          end
        end
        StZeros: begin
          if (TotalZerosWr) begin
            zerosLeftD = {1'b0, TotalZeros};
            posD       = posInit;
            kD         = 5'd0;
`ifdef COEFF_ASSEMBLE_ERRCHK_EN
            errorD     = errorQ | sumOver;
`endif
          end
        end
        StRuns: begin
          if (runStep) begin
            coeffArrD[posQ[3:0]] = levelBufQ[kQ[3:0]];
            posD       = posStep;
            zerosLeftD = zerosLeftQ - runVal;
            kD         = kQ + 5'd1;
            emitIdxD   = 4'd0;
`ifdef COEFF_ASSEMBLE_ERRCHK_EN
            errorD     = errorQ | runOver;
`endif
          end
        end
        StEmit: begin
          if (transfer) begin
            emitIdxD = emitLast ? 4'd0 : emitIdxQ + 4'd1;
          end
        end
        default: begin
          emitIdxD = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      totalCoeffQ <= 5'd0;
      kQ          <= 5'd0;
      posQ        <= 5'd0;
      zerosLeftQ  <= 5'd0;
      emitIdxQ    <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        levelBufQ[i] <= 13'd0;
        coeffArrQ[i] <= 13'd0;
      end
    end else begin
      totalCoeffQ <= totalCoeffD;
      kQ          <= kD;
      posQ        <= posD;
      zerosLeftQ  <= zerosLeftD;
      emitIdxQ    <= emitIdxD;
      levelBufQ   <= levelBufD;
      coeffArrQ   <= coeffArrD;
    end
  end

`ifdef COEFF_ASSEMBLE_ERRCHK_EN
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      errorQ <= 1'b0;
    end else begin
      errorQ <= errorD;
    end
  end
`endif

endmodule
